// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown sequencer.
package countdown_pkg;

    localparam int unsigned DefaultDw = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/countdown_core.sv
// Counter datapath: clear, load, saturating decrement or hold, with async clear on reset.
module countdown_core
    import countdown_pkg::*;
#(
    parameter int unsigned DW = DefaultDw
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          load,
    input  logic          dec,
    input  logic [DW-1:0] load_val,
    output logic [DW-1:0] count
);

    localparam logic [DW-1:0] One = DW'(1);

    logic [DW-1:0] count_q, count_d;

    // Priority clear > load > decrement; decrement never goes below zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - One;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/countdown_seq.sv
// Countdown sequencer: IDLE/RUN/PAUSE/DONE control around countdown_core.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic mode (reload on expiry instead of DONE).
module countdown_seq
    import countdown_pkg::*;
#(
    parameter int unsigned DW           = DefaultDw,
    parameter int unsigned DEFAULT_LOAD = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] load_val,
    input  logic          use_default,
    input  logic          pause,
    input  logic          abort,
    input  logic          ack,
    output logic [DW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic          expired
);

    localparam logic [DW-1:0] DefLoad = DW'(DEFAULT_LOAD);
    localparam logic [DW-1:0] One     = DW'(1);

    state_e        state_q, state_d;
    logic          expired_q, expired_d;
    logic          core_clr, core_load, core_dec;
    logic [DW-1:0] core_val;
    logic [DW-1:0] eff_load;

    assign eff_load = ((load_val == '0) && use_default) ? DefLoad : load_val;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [DW-1:0] reload_q, reload_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        expired_d = 1'b0;
        core_clr  = 1'b0;
        core_load = 1'b0;
        core_dec  = 1'b0;
        core_val  = eff_load;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d  = reload_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    core_load = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    reload_d  = eff_load;
`endif
                    if (eff_load == '0) begin
                        state_d   = StDone;
                        expired_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    core_clr = 1'b1;
                    state_d  = StIdle;
                end else if (pause) begin
                    state_d = StPause;
                end else if (count == One) begin
                    expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    core_load = 1'b1;
                    core_val  = reload_q;
`else
                    core_dec  = 1'b1;
                    state_d   = StDone;
`endif
                end else begin
                    core_dec = 1'b1;
                end
            end
            StPause: begin
                if (abort) begin
                    core_clr = 1'b1;
                    state_d  = StIdle;
                end else if (!pause) begin
                    // Resume without decrementing on this edge.
                    state_d = StRun;
                end
            end
            StDone: begin
                if (ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            expired_q <= expired_d;
        end
    end

    countdown_core #(
        .DW(DW)
    ) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (core_clr),
        .load     (core_load),
        .dec      (core_dec),
        .load_val (core_val),
        .count    (count)
    );

    assign busy    = (state_q == StRun) || (state_q == StPause);
    assign done    = (state_q == StDone);
    assign expired = expired_q;

endmodule

// File: doc/countdown_seq.md
COUNTDOWN_SEQ -- requirements
Module: countdown_seq

Interface
REQ-001 Parameters SHALL be:
- DW, default 8, width of count and load value.
- DEFAULT_LOAD, default 7, value loaded when load_val is 0 and use_default is high.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- reset_n, in, 1, reset; asynchronous, active-low.
- start, in, 1, request to begin a countdown; sampled only in IDLE.
- load_val, in, DW, start value; captured on an accepted start.
- use_default, in, 1, substitute DEFAULT_LOAD when load_val is 0.
- pause, in, 1, level; freezes the countdown while high.
- abort, in, 1, terminates the countdown and returns to IDLE.
- ack, in, 1, consumer acknowledge of done.
- count, out, DW, current counter value.
- busy, out, 1, high in RUN or PAUSE.
- done, out, 1, high in DONE.
- expired, out, 1, one-cycle pulse when the count reaches 0.

Function
REQ-003 The block SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-004 The effective start value SHALL be: DEFAULT_LOAD when load_val is 0 and use_default is 1; load_val otherwise.
REQ-005 In IDLE, start=1 SHALL set count to the effective start value. The next state is RUN if that value is nonzero, else DONE with expired pulsed in that same edge.
REQ-006 In RUN, priority SHALL be abort > pause > decrement.
- abort: count becomes 0 and the state goes to IDLE, with no expired pulse.
- pause: count holds and the state goes to PAUSE.
- otherwise: count decrements by 1.
REQ-007 In RUN with count equal to 1 and no abort or pause, count SHALL become 0, expired SHALL pulse for exactly one cycle, and the state SHALL go to DONE.
REQ-008 Latency: start with value N>0 SHALL yield expired exactly N cycles after the accepting edge, given no pause.
REQ-009 In PAUSE, count SHALL hold.
- abort=1 goes to IDLE with count 0.
- pause=0 goes to RUN, with no decrement on that edge.
REQ-010 Each paused cycle SHALL extend the latency by exactly one cycle.
REQ-011 In DONE, done SHALL stay high and count SHALL stay 0 until ack=1, which goes to IDLE; start SHALL be ignored in DONE, including on the ack cycle.
REQ-012 The start, ack and pause inputs SHALL have no effect in any state not listed for them above.
REQ-013 Count SHALL never wrap below 0; decrement SHALL be unsigned modulo-free arithmetic of width DW.

Reset
REQ-014 reset_n=0 SHALL asynchronously force: state IDLE, count 0, busy 0, done 0, expired 0, and a cleared reload register.
REQ-015 Reset asserted mid-countdown SHALL abandon the count; after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-016 With macro COUNTDOWN_AUTO_RELOAD_EN defined:
- An accepted start latches the effective start value into a reload register.
- RUN with count 1 reloads count from that register, pulses expired, and stays in RUN (periodic mode).
- DONE is reached only via a zero effective start value.
REQ-017 Without COUNTDOWN_AUTO_RELOAD_EN, the reload register SHALL be absent and behaviour SHALL follow REQ-007.

Structure
REQ-018 Package countdown_pkg SHALL hold:
- the state enum type (2-bit encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3);
- the default DW constant.
REQ-019 The datapath SHALL be a sub-module countdown_core (load, decrement when enabled, hold, async clear), driven by countdown_seq.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then start with load_val=5: count sequence 5,4,3,2,1,0; expired pulses on the edge count becomes 0; done high until ack; then IDLE.
- load_val=0 with use_default=1: count loads 7 and expired comes 7 cycles later. load_val=0 with use_default=0: DONE on the next edge with expired pulsed.
- load_val=4 with pause high for 3 cycles at count 2: expired 7 cycles after start; count holds at 2 while paused.
- Abort at count 3 while pause is also high: IDLE with count 0, no expired pulse, busy 0 on the next edge.
- reset_n pulsed low asynchronously mid-RUN at count 6: outputs clear immediately, independent of clk; a later start of 2 works normally.
- With COUNTDOWN_AUTO_RELOAD_EN defined and load_val=3: expired every 3 cycles, count sequence 3,2,1,3,2,1...; abort returns to IDLE.
